// File: rtl/program_counter.sv
// Program counter with previous-PC shadow and a registered load pulse.
// Latency: one edge from a qualified enable to output_PC. Backpressure: none, every qualified load is accepted.
// All outputs come straight from flops, so there is no input-to-output combinational path.
module program_counter #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             input_PC_PCWrite,
    input  logic             input_PC_PCWriteCond,
    input  logic             input_PC_cond,
    input  logic [WIDTH-1:0] input_PC_newPC,
    output logic [WIDTH-1:0] output_PC,
    output logic [WIDTH-1:0] output_PC_old,
    output logic             output_PC_loaded
);

    logic             pc_load;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_old_q;
    logic             loaded_q;

    // PCWrite dominates; cond only matters while a branch state asserts PCWriteCond.
    assign pc_load = input_PC_PCWrite | (input_PC_PCWriteCond & input_PC_cond);

    // newPC is only sampled under pc_load, so garbage on it while idle never reaches state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q     <= RESET_VECTOR;
            pc_old_q <= RESET_VECTOR;
            loaded_q <= 1'b0;
        end else if (pc_load) begin
            pc_q     <= input_PC_newPC;
            pc_old_q <= pc_q;
            loaded_q <= 1'b1;
        end else begin
            loaded_q <= 1'b0;
        end
    end

    assign output_PC        = pc_q;
    assign output_PC_old    = pc_old_q;
    assign output_PC_loaded = loaded_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus randomized traffic against a reference model.
module tb_program_counter;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        input_PC_PCWrite = 1'b0;
    logic        input_PC_PCWriteCond = 1'b0;
    logic        input_PC_cond = 1'b0;
    logic [15:0] input_PC_newPC = 16'h0000;
    logic [15:0] output_PC;
    logic [15:0] output_PC_old;
    logic        output_PC_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural view of the PC
    logic [15:0] m_pc  = 16'h0000;
    logic [15:0] m_old = 16'h0000;
    logic        m_ld  = 1'b0;

    program_counter #(.WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
        .CLK                  (CLK),
        .RESET_N              (RESET_N),
        .input_PC_PCWrite     (input_PC_PCWrite),
        .input_PC_PCWriteCond (input_PC_PCWriteCond),
        .input_PC_cond        (input_PC_cond),
        .input_PC_newPC       (input_PC_newPC),
        .output_PC            (output_PC),
        .output_PC_old        (output_PC_old),
        .output_PC_loaded     (output_PC_loaded)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of inputs at the falling edge, advance past the rising edge, update the model.
    task automatic apply(input logic rst_n, input logic w, input logic wc, input logic c,
                         input logic [15:0] np);
        @(negedge CLK);
        RESET_N              = rst_n;
        input_PC_PCWrite     = w;
        input_PC_PCWriteCond = wc;
        input_PC_cond        = c;
        input_PC_newPC       = np;
        @(posedge CLK);
        #1;
        if (!rst_n) begin
            m_pc  = 16'h0000;
            m_old = 16'h0000;
            m_ld  = 1'b0;
        end else if (w || (wc && c)) begin
            m_old = m_pc;
            m_pc  = np;
            m_ld  = 1'b1;
        end else begin
            m_ld = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (output_PC !== 16'h0000) $display("FAIL reset_pc got %h want 0000", output_PC);
        else n_pass++;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h00A5);
        n_checks++;
        if (output_PC !== 16'h0000) $display("FAIL hold_pc got %h want 0000", output_PC);
        else n_pass++;
        n_checks++;
        if (output_PC_old !== 16'h0000) $display("FAIL hold_old got %h want 0000", output_PC_old);
        else n_pass++;
        n_checks++;
        if (output_PC_loaded !== 1'b0) $display("FAIL hold_loaded got %b want 0", output_PC_loaded);
        else n_pass++;
    endtask

    task automatic test_uncond_load();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234);
        n_checks++;
        if (output_PC !== 16'h1234) $display("FAIL load1_pc got %h want 1234", output_PC);
        else n_pass++;
        n_checks++;
        if (output_PC_old !== 16'h0000) $display("FAIL load1_old got %h want 0000", output_PC_old);
        else n_pass++;
        n_checks++;
        if (output_PC_loaded !== 1'b1) $display("FAIL load1_loaded got %b want 1", output_PC_loaded);
        else n_pass++;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h5678);
        n_checks++;
        if (output_PC !== 16'h5678) $display("FAIL load2_pc got %h want 5678", output_PC);
        else n_pass++;
        n_checks++;
        if (output_PC_old !== 16'h1234) $display("FAIL load2_old got %h want 1234", output_PC_old);
        else n_pass++;
        n_checks++;
        if (output_PC_loaded !== 1'b1) $display("FAIL load2_loaded got %b want 1", output_PC_loaded);
        else n_pass++;
    endtask

    task automatic test_cond_branch();
        apply(1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF);
        n_checks++;
        if (output_PC !== 16'h5678) $display("FAIL br_nt_pc got %h want 5678", output_PC);
        else n_pass++;
        n_checks++;
        if (output_PC_loaded !== 1'b0) $display("FAIL br_nt_loaded got %b want 0", output_PC_loaded);
        else n_pass++;
        // cond alone without PCWriteCond must not load
        apply(1'b1, 1'b0, 1'b0, 1'b1, 16'hDEAD);
        n_checks++;
        if (output_PC !== 16'h5678) $display("FAIL cond_only_pc got %h want 5678", output_PC);
        else n_pass++;
        apply(1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF);
        n_checks++;
        if (output_PC !== 16'hBEEF) $display("FAIL br_t_pc got %h want beef", output_PC);
        else n_pass++;
        n_checks++;
        if (output_PC_old !== 16'h5678) $display("FAIL br_t_old got %h want 5678", output_PC_old);
        else n_pass++;
        n_checks++;
        if (output_PC_loaded !== 1'b1) $display("FAIL br_t_loaded got %b want 1", output_PC_loaded);
        else n_pass++;
    endtask

    task automatic test_priority_hold();
        logic [15:0] toggle [3];
        toggle[0] = 16'h0001;
        toggle[1] = 16'h8000;
        toggle[2] = 16'h0001;
        apply(1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF);
        n_checks++;
        if (output_PC !== 16'hFFFF) $display("FAIL prio_pc got %h want ffff", output_PC);
        else n_pass++;
        n_checks++;
        if (output_PC_old !== 16'hBEEF) $display("FAIL prio_old got %h want beef", output_PC_old);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b1, toggle[i]);
            n_checks++;
            if (output_PC !== 16'hFFFF || output_PC_loaded !== 1'b0)
                $display("FAIL idle_hold[%0d] got pc=%h ld=%b want pc=ffff ld=0", i, output_PC, output_PC_loaded);
            else n_pass++;
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, 16'hxxxx);
        n_checks++;
        if (output_PC !== 16'hFFFF || output_PC_old !== 16'hBEEF)
            $display("FAIL x_newpc got pc=%h old=%h want pc=ffff old=beef", output_PC, output_PC_old);
        else n_pass++;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 16'hzzzz);
        n_checks++;
        if (output_PC !== 16'hFFFF || output_PC_loaded !== 1'b0)
            $display("FAIL z_newpc got pc=%h ld=%b want pc=ffff ld=0", output_PC, output_PC_loaded);
        else n_pass++;
        // odd address and zero load verbatim
        apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0003);
        n_checks++;
        if (output_PC !== 16'h0003 || output_PC_old !== 16'h0000)
            $display("FAIL odd_load got pc=%h old=%h want pc=0003 old=0000", output_PC, output_PC_old);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h5678);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (output_PC !== 16'h5678) $display("FAIL pre_rst_pc got %h want 5678", output_PC);
        else n_pass++;
        #2;
        RESET_N = 1'b0;
        #1;
        n_checks++;
        if (output_PC !== 16'h0000 || output_PC_old !== 16'h0000 || output_PC_loaded !== 1'b0)
            $display("FAIL async_rst got pc=%h old=%h ld=%b want 0000/0000/0", output_PC, output_PC_old, output_PC_loaded);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b1, 16'hA5A5);
            n_checks++;
            if (output_PC !== 16'h0000 || output_PC_loaded !== 1'b0)
                $display("FAIL rst_held[%0d] got pc=%h ld=%b want 0000/0", i, output_PC, output_PC_loaded);
            else n_pass++;
        end
        // first edge after release evaluates enables normally
        apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h4242);
        n_checks++;
        if (output_PC !== 16'h4242 || output_PC_old !== 16'h0000)
            $display("FAIL post_rst_load got pc=%h old=%h want 4242/0000", output_PC, output_PC_old);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        r, w, wc, c;
        logic [15:0] np;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            w  = ($urandom_range(0, 3) == 0);
            wc = $urandom_range(0, 1) == 1;
            c  = $urandom_range(0, 1) == 1;
            np = 16'($urandom);
            apply(r, w, wc, c, np);
            n_checks++;
            if (output_PC !== m_pc || output_PC_old !== m_old || output_PC_loaded !== m_ld)
                $display("FAIL rand[%0d] got pc=%h old=%h ld=%b want pc=%h old=%h ld=%b",
                         i, output_PC, output_PC_old, output_PC_loaded, m_pc, m_old, m_ld);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_uncond_load();
        test_cond_branch();
        test_priority_hold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Program counter register for the 16-bit multi-cycle processor datapath.
- Holds the current instruction address, which feeds memory address muxing and the ALU source muxes.
- Loads a new address from the PC-source mux under an unconditional write enable (fetch, jumps) or a conditional write enable qualified by a branch-condition flag (branches).
- Also keeps the previous PC value, used for link and offset computation in later multi-cycle states.

Parameters:
- WIDTH, 16, address width in bits for all PC data paths.
- RESET_VECTOR, 16'h0000, value loaded into the PC on reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- input_PC_PCWrite  input  1  unconditional load enable from the control unit.
- input_PC_PCWriteCond  input  1  conditional load enable (branch states).
- input_PC_cond  input  1  branch condition flag from the ALU/comparator; qualifies input_PC_PCWriteCond.
- input_PC_newPC  input  WIDTH  candidate next PC value from the PC-source mux.
- output_PC  output  WIDTH  current PC, driven directly from the register.
- output_PC_old  output  WIDTH  PC value held immediately before the most recent load.
- output_PC_loaded  output  1  one-cycle pulse, high in the cycle after a load occurred.

Behaviour:
- Reset: RESET_N low clears state immediately, independent of CLK.
  - output_PC = RESET_VECTOR.
  - output_PC_old = RESET_VECTOR.
  - output_PC_loaded = 0.
  - State is held while RESET_N stays low. Reset asserted mid-operation discards any pending load.
- Reset release: the first rising edge with RESET_N high evaluates the enables normally. There is no extra synchronisation cycle inside the block.
- Load condition: load = input_PC_PCWrite OR (input_PC_PCWriteCond AND input_PC_cond).
- On a rising edge with load = 1:
  - output_PC <= input_PC_newPC.
  - output_PC_old <= the output_PC value before the edge.
  - output_PC_loaded <= 1.
- On a rising edge with load = 0:
  - output_PC and output_PC_old hold.
  - output_PC_loaded <= 0.
- Enable priority: input_PC_PCWrite dominates. If it is high, the load happens regardless of PCWriteCond or cond. With both enables high the result is a single load, identical to PCWrite alone.
- input_PC_cond is ignored unless input_PC_PCWriteCond is high.
- Latency: a new value is visible on output_PC one clock edge after it is presented with load = 1. Back-to-back loads on consecutive edges are each accepted.
- Value range:
  - No alignment checking or masking; any WIDTH-bit value loads verbatim, including odd addresses, 16'hFFFF and 16'h0000.
  - No internal increment; PC+2 is computed externally and presented on input_PC_newPC.
  - No wrap or saturation logic.
- Combinational and timing rules:
  - No combinational path from any input to any output; all outputs are registered.
  - input_PC_newPC changing while load = 0 has no effect.
  - X or Z on input_PC_newPC while load = 0 must not propagate to outputs.

Test Plan:
- Reset then hold: RESET_N=0 for 2 cycles, release, PCWrite=0, newPC=16'h00A5 for 1 edge -> output_PC=16'h0000, output_PC_old=16'h0000, output_PC_loaded=0.
- Unconditional loads:
  - PCWrite=1, newPC=16'h1234, one edge -> output_PC=16'h1234, output_PC_old=16'h0000, loaded=1.
  - Next edge with newPC=16'h5678 -> output_PC=16'h5678, output_PC_old=16'h1234.
- Conditional branch: PCWrite=0, PCWriteCond=1.
  - cond=0, newPC=16'hBEEF, one edge -> PC unchanged, loaded=0.
  - cond=1, next edge -> output_PC=16'hBEEF.
- Priority: PCWrite=1, PCWriteCond=1, cond=0, newPC=16'hFFFF -> output_PC=16'hFFFF.
  - Then PCWrite=0, PCWriteCond=0, newPC toggled across 16'h0001 and 16'h8000 for 3 edges -> PC stays 16'hFFFF, loaded=0.
- Async reset mid-operation: PC=16'h5678, drop RESET_N between clock edges -> output_PC=16'h0000 and output_PC_old=16'h0000 before the next rising edge.
  - Edges while reset is low with PCWrite=1 -> outputs stay at 16'h0000.
